en_strobe_gen: RTL

Programmable enable-strobe generator: the producing end of the clock-enable interface consumed by enable-gated registers such as the D flip-flop with enable. On `start` it latches a period and a strobe count. It then emits single-cycle `en` pulses every `div` clocks, either for a fixed-length burst or continuously until `stop`. Status outputs let a controller sequence bursts.

---
 rtl/en_strobe_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/en_strobe_gen.sv
// Programmable enable-strobe generator: after an accepted start it emits one-cycle
// en pulses every max(div,1) clocks, for num strobes or continuously until stop.
module en_strobe_gen #(
    parameter int CW = 8,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] div,
    input  logic [NW-1:0] num,
    output logic          en,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] sent
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] num_q, num_d;
    logic [NW-1:0] sent_q, sent_d;
    logic          en_q, en_d;
    logic          done_q, done_d;

    logic [CW-1:0] period_last;
    logic [CW-1:0] cnt_wrap;
    logic [NW-1:0] sent_inc;
    logic          final_strobe;

    // en_q is high exactly when cnt_q sits at P-1, so the strobe seen this cycle
    // is the one being counted and tested for "final" here.
    assign period_last  = period_q - CW'(1);
    assign cnt_wrap     = (cnt_q == period_last) ? '0 : cnt_q + CW'(1);
    assign sent_inc     = sent_q + NW'(1);
    assign final_strobe = en_q && (num_q != '0) && (sent_inc == num_q);

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        sent_d   = sent_q;
        en_d     = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    period_d = (div == '0) ? CW'(1) : div;
                    num_d    = num;
                    cnt_d    = '0;
                    sent_d   = '0;
                    en_d     = (period_d == CW'(1));
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (en_q) begin
                    sent_d = sent_inc;
                end
                // A final strobe completes the burst even if stop arrives with it.
                if (final_strobe) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (stop) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_wrap;
                    en_d  = (cnt_wrap == period_last);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            period_q <= CW'(1);
            cnt_q    <= '0;
            num_q    <= '0;
            sent_q   <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            sent_q   <= sent_d;
            en_q     <= en_d;
            done_q   <= done_d;
        end
    end

    assign en   = en_q;
    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign sent = sent_q;

endmodule
